exception_sequencer: RTL and testbench
======================================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 exc_opcode  in  1  invalid-opcode request from control unit; level, sampled in IDLE.
REQ-005 exc_overflow  in  1  ALU overflow request; level, sampled in IDLE.
REQ-006 exc_div0  in  1  divide-by-zero request from divider; level, sampled in IDLE.
REQ-007 pc_in  in  32  current PC (already incremented by 4).
REQ-008 mem_data_in  in  32  memory read data; only bits [7:0] used.
REQ-009 busy  out  1  high from the cycle after acceptance through the LOAD_PC cycle.
REQ-010 mem_addr  out  32  byte address presented to memory during SAVE_EPC, WAIT1 and WAIT2.
REQ-011 addr_sel  out  1  high when mem_addr SHALL drive the memory address mux.
REQ-012 epc_write  out  1  one-cycle EPC load strobe.
REQ-013 epc_value  out  32  value to load into EPC.
REQ-014 pc_write  out  1  one-cycle PC load strobe.
REQ-015 handler_pc  out  32  handler address for PC.
REQ-016 cause  out  2  latched code: 00 none, 01 opcode, 10 overflow, 11 div0.
REQ-017 exc_count  out  8  saturating count of accepted exceptions.

Function
REQ-018 States SHALL be IDLE, SAVE_EPC, WAIT1, WAIT2, LOAD_PC.
REQ-019 IDLE: if any request is high, latch cause and pc_in, then go to SAVE_EPC; otherwise stay in IDLE.
REQ-020 Priority on simultaneous requests SHALL be opcode > overflow > div0.
REQ-021 Vector byte addresses SHALL be: opcode 253, overflow 254, div0 255 (zero-extended to 32 bits).
REQ-022 SAVE_EPC: epc_write=1, epc_value=latched pc_in - 4 (mod 2^32; pc_in=0 gives 0xFFFFFFFC), addr_sel=1, mem_addr=vector; next state WAIT1.
REQ-023 WAIT1 and WAIT2: addr_sel=1, mem_addr held; memory data is valid in WAIT2 (two-cycle read latency).
REQ-024 LOAD_PC: handler_pc={24'b0, byte registered in WAIT2}, pc_write=1; next state IDLE.
REQ-025 Latency SHALL be four cycles: request sampled at edge N; pc_write is high in cycle N+4.
REQ-026 Requests while busy SHALL be ignored and not queued; a request still high on return to IDLE SHALL be accepted.
REQ-027 exc_count SHALL increment on acceptance and saturate at 255.
REQ-028 Outside their states, epc_write, pc_write and addr_sel SHALL be 0; mem_addr, epc_value and handler_pc SHALL hold their last values.
REQ-029 cause SHALL hold until the next acceptance.

Reset
REQ-030 Reset SHALL force IDLE with busy, epc_write, pc_write, addr_sel=0; mem_addr, epc_value, handler_pc=0; cause=00; exc_count=0.
REQ-031 Reset in any state SHALL abort the sequence with no strobes in that cycle.
REQ-032 Reset SHALL take precedence over a simultaneous request.

Structure
REQ-033 Shared package exception_pkg SHALL hold the state encoding, cause codes and vector addresses 253/254/255.
REQ-034 One sub-module, exception_vector_decode, SHALL be a combinational priority encoder from the three requests to cause and vector address.

Verification
REQ-035 Overflow only, pc_in=0x00000040, memory[254]=0x7C -> epc_write in cycle N+1 with epc_value 0x3C; pc_write in cycle N+4 with handler_pc 0x7C; cause 10.
REQ-036 All three requests in the same cycle -> cause 01, mem_addr 253, only one exception counted.
REQ-037 div0 asserted during WAIT1 of an opcode exception -> ignored; if held, accepted in the first IDLE cycle after LOAD_PC.
REQ-038 Reset asserted in WAIT2 -> no pc_write, next cycle IDLE, all outputs 0.
REQ-039 300 back-to-back accepted exceptions -> exc_count stops at 255.
REQ-040 pc_in=0x00000000 -> epc_value 0xFFFFFFFC; memory[255]=0xFF -> handler_pc 0x000000FF.

Source files
------------

// File: rtl/exception_pkg.sv
// Shared definitions for the exception sequencer: FSM state encoding,
// cause codes and the fixed handler vector byte addresses.
package exception_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_EPC = 3'd1,
    ST_WAIT1    = 3'd2,
    ST_WAIT2    = 3'd3,
    ST_LOAD_PC  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV0     = 2'b11
  } cause_t;

  localparam logic [31:0] VEC_OPCODE   = 32'd253;
  localparam logic [31:0] VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] VEC_DIV0     = 32'd255;

  localparam logic [7:0]  EXC_COUNT_MAX = 8'd255;

endpackage

// File: rtl/exception_vector_decode.sv
// Combinational priority encoder: opcode > overflow > div0.
// Produces the cause code and the vector byte address for the winner;
// any_req flags that at least one request is pending.
module exception_vector_decode
  import exception_pkg::*;
(
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  output logic        any_req,
  output logic [1:0]  cause,
  output logic [31:0] vector
);

  // Highest-priority request selects both the code and the vector
  always_comb begin
    any_req = exc_opcode | exc_overflow | exc_div0;
    cause   = CAUSE_NONE;
    vector  = 32'd0;
    if (exc_opcode) begin
      cause  = CAUSE_OPCODE;
      vector = VEC_OPCODE;
    end else if (exc_overflow) begin
      cause  = CAUSE_OVERFLOW;
      vector = VEC_OVERFLOW;
    end else if (exc_div0) begin
      cause  = CAUSE_DIV0;
      vector = VEC_DIV0;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: saves EPC, reads the handler byte from the
// vector table (two-cycle memory latency) and loads it into the PC.
// Request sampled at edge N gives pc_write in cycle N+4; requests while busy are dropped.
module exception_sequencer
  import exception_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        addr_sel,
  output logic        epc_write,
  output logic [31:0] epc_value,
  output logic        pc_write,
  output logic [31:0] handler_pc,
  output logic [1:0]  cause,
  output logic [7:0]  exc_count
);

  state_t      state_q;
  state_t      state_d;
  logic        dec_any;
  logic [1:0]  dec_cause;
  logic [31:0] dec_vector;
  logic        accept;
  logic        unused_mem_hi;

  // Only the low byte of the vector table entry is meaningful
  assign unused_mem_hi = ^mem_data_in[31:8];

  exception_vector_decode u_decode (
    .exc_opcode  (exc_opcode),
    .exc_overflow(exc_overflow),
    .exc_div0    (exc_div0),
    .any_req     (dec_any),
    .cause       (dec_cause),
    .vector      (dec_vector)
  );

  assign accept = (state_q == ST_IDLE) && dec_any;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed walk through the save/read/load steps once accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (dec_any) state_d = ST_SAVE_EPC;
      ST_SAVE_EPC: state_d = ST_WAIT1;
      ST_WAIT1:    state_d = ST_WAIT2;
      ST_WAIT2:    state_d = ST_LOAD_PC;
      ST_LOAD_PC:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Strobes decoded from state; a reset cycle suppresses them so an
  // aborted sequence never emits a partial write
  always_comb begin
    busy      = 1'b0;
    addr_sel  = 1'b0;
    epc_write = 1'b0;
    pc_write  = 1'b0;
    if (!reset) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_SAVE_EPC: begin
          epc_write = 1'b1;
          addr_sel  = 1'b1;
        end
        ST_WAIT1, ST_WAIT2: addr_sel = 1'b1;
        ST_LOAD_PC:         pc_write = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath registers: captured on acceptance (or in WAIT2 for the
  // handler byte) and held otherwise so downstream muxes see stable values
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= 32'd0;
      epc_value  <= 32'd0;
      handler_pc <= 32'd0;
      cause      <= CAUSE_NONE;
      exc_count  <= 8'd0;
    end else begin
      if (accept) begin
        mem_addr  <= dec_vector;
        epc_value <= pc_in - 32'd4;
        cause     <= dec_cause;
        if (exc_count != EXC_COUNT_MAX) exc_count <= exc_count + 8'd1;
      end
      if (state_q == ST_WAIT2) handler_pc <= {24'd0, mem_data_in[7:0]};
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: a cycle-count model predicts
// acceptances and pushes expected EPC/handler/cause/count entries that are
// checked when the DUT raises epc_write and pc_write.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;
  logic        busy, addr_sel, epc_write, pc_write;
  logic [31:0] mem_addr, epc_value, handler_pc;
  logic [1:0]  cause;
  logic [7:0]  exc_count;

  always #5 clk = ~clk;

  exception_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .exc_opcode  (exc_opcode),
    .exc_overflow(exc_overflow),
    .exc_div0    (exc_div0),
    .pc_in       (pc_in),
    .mem_data_in (mem_data_in),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .addr_sel    (addr_sel),
    .epc_write   (epc_write),
    .epc_value   (epc_value),
    .pc_write    (pc_write),
    .handler_pc  (handler_pc),
    .cause       (cause),
    .exc_count   (exc_count)
  );

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [31:0] hpc;
    logic [7:0]  cnt;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem [256];
  logic [7:0] p1;
  int         cyc = 0;
  int         phase = 0;
  logic [7:0] cnt_m = 8'd0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic exp_t mk_exp(input logic op, input logic ov, input logic [31:0] pc,
                                  input logic [7:0] cnt, input int acc);
    exp_t e;
    if (op)      begin e.cause = 2'b01; e.vec = 32'd253; end
    else if (ov) begin e.cause = 2'b10; e.vec = 32'd254; end
    else         begin e.cause = 2'b11; e.vec = 32'd255; end
    e.epc = pc - 32'd4;
    e.hpc = {24'd0, mem[e.vec[7:0]]};
    e.cnt = (cnt == 8'd255) ? 8'd255 : cnt + 8'd1;
    e.acc = acc;
    return e;
  endfunction

  // Memory with two-cycle read latency; junk in the upper bytes
  always @(posedge clk) begin
    p1          <= mem[mem_addr[7:0]];
    mem_data_in <= {24'hA5C3E1, p1};
  end

  // Acceptance model: phase 0 idle, 1..4 = save, wait, wait, load
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      phase <= 0;
      cnt_m <= 8'd0;
      q.delete();
    end else if (phase == 0) begin
      if (exc_opcode || exc_overflow || exc_div0) begin
        q.push_back(mk_exp(exc_opcode, exc_overflow, pc_in, cnt_m, cyc));
        cnt_m <= (cnt_m == 8'd255) ? 8'd255 : cnt_m + 8'd1;
        phase <= 1;
      end
    end else begin
      phase <= (phase == 4) ? 0 : phase + 1;
    end
  end

  // Monitor: strobe shape every cycle, scoreboard contents at the strobes
  always @(negedge clk) begin
    check("epc_write", {31'd0, epc_write}, {31'd0, !reset && phase == 1});
    check("addr_sel",  {31'd0, addr_sel},  {31'd0, !reset && phase >= 1 && phase <= 3});
    check("pc_write",  {31'd0, pc_write},  {31'd0, !reset && phase == 4});
    check("busy",      {31'd0, busy},      {31'd0, !reset && phase != 0});
    if (epc_write) begin
      if (q.size() == 0) check("epc_unexpected", 32'd1, 32'd0);
      else begin
        check("epc_value",   epc_value, q[0].epc);
        check("mem_addr",    mem_addr,  q[0].vec);
        check("cause",       {30'd0, cause}, {30'd0, q[0].cause});
        check("epc_latency", cyc, q[0].acc + 1);
      end
    end
    if (pc_write) begin
      if (q.size() == 0) check("pc_unexpected", 32'd1, 32'd0);
      else begin
        check("handler_pc", handler_pc, q[0].hpc);
        check("exc_count",  {24'd0, exc_count}, {24'd0, q[0].cnt});
        check("pc_latency", cyc, q[0].acc + 4);
        void'(q.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0 && phase == 0 && !busy) break;
    end
    check("drain", q.size(), 32'd0);
  endtask

  task automatic pulse(input logic op, input logic ov, input logic dz, input logic [31:0] pc);
    exc_opcode = op; exc_overflow = ov; exc_div0 = dz; pc_in = pc;
    @(negedge clk);
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[253] = 8'h33;
    mem[254] = 8'h7C;
    mem[255] = 8'hFF;
    reset = 1'b1;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = 32'h0000_1000;
    repeat (2) @(negedge clk);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_epc_value", epc_value, 32'd0);
    check("rst_handler",   handler_pc, 32'd0);
    check("rst_cause",     {30'd0, cause}, 32'd0);
    check("rst_count",     {24'd0, exc_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Overflow only, pc 0x40 -> epc 0x3C, handler 0x7C, cause 10
    pulse(1'b0, 1'b1, 1'b0, 32'h0000_0040);
    drain();
    check("ovf_cause",   {30'd0, cause}, 32'd2);
    check("ovf_epc",     epc_value, 32'h0000_003C);
    check("ovf_handler", handler_pc, 32'h0000_007C);

    // All three at once -> opcode wins, counted once
    pulse(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    drain();
    check("all3_cause", {30'd0, cause}, 32'd1);
    check("all3_addr",  mem_addr, 32'd253);
    check("all3_count", {24'd0, exc_count}, 32'd2);

    // div0 raised during WAIT1 of an opcode exception, held into IDLE
    pulse(1'b1, 1'b0, 1'b0, 32'h0000_3004);
    @(negedge clk);
    exc_div0 = 1'b1; pc_in = 32'h0000_4008;
    repeat (4) @(negedge clk);
    exc_div0 = 1'b0;
    drain();
    check("late_div0_cause", {30'd0, cause}, 32'd3);
    check("late_div0_count", {24'd0, exc_count}, 32'd4);

    // Reset during WAIT2 aborts without pc_write
    pulse(1'b1, 1'b0, 1'b0, 32'h0000_5000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pc_write", {31'd0, pc_write}, 32'd0);
    check("abort_busy",     {31'd0, busy}, 32'd0);
    check("abort_addr_sel", {31'd0, addr_sel}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_epc",      epc_value, 32'd0);
    check("abort_handler",  handler_pc, 32'd0);
    check("abort_cause",    {30'd0, cause}, 32'd0);
    check("abort_count",    {24'd0, exc_count}, 32'd0);
    // Reset wins over a simultaneous request
    exc_opcode = 1'b1;
    @(negedge clk);
    exc_opcode = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_prio_count", {24'd0, exc_count}, 32'd0);

    // pc 0 wraps to 0xFFFFFFFC; handler byte 0xFF
    pulse(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    drain();
    check("wrap_epc",     epc_value, 32'hFFFF_FFFC);
    check("wrap_handler", handler_pc, 32'h0000_00FF);

    // 300 back-to-back acceptances saturate the counter
    exc_overflow = 1'b1; pc_in = 32'h0000_8000;
    repeat (1500) @(negedge clk);
    exc_overflow = 1'b0;
    drain();
    check("sat_count", {24'd0, exc_count}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
